// File: rtl/midi_pkg.sv
// Shared MIDI message codes, controller numbers and voice-allocator types.
// Optional sustain-pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_EN.
package midi_pkg;

    localparam logic [3:0] MSG_NOTE_OFF     = 4'h8;
    localparam logic [3:0] MSG_NOTE_ON      = 4'h9;
    localparam logic [3:0] MSG_CC           = 4'hB;
    localparam logic [6:0] CC_SUSTAIN       = 7'd64;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    // One accepted parser message, frozen for the duration of its processing.
    typedef struct packed {
        logic [3:0] msg;
        logic [6:0] note;
        logic [6:0] vel;
        logic [6:0] lsb;
        logic [6:0] msb;
    } midi_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } alloc_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ON,
        OP_OFF,
        OP_ALL_OFF,
        OP_SUSTAIN
    } alloc_op_t;

    // Classify an event; a NOTE ON with zero velocity is a NOTE OFF.
    function automatic alloc_op_t decode_op(input midi_event_t ev);
        alloc_op_t op;
        op = OP_NONE;
        if (ev.msg == MSG_NOTE_ON && ev.vel != 7'd0)
            op = OP_ON;
        else if (ev.msg == MSG_NOTE_ON || ev.msg == MSG_NOTE_OFF)
            op = OP_OFF;
        else if (ev.msg == MSG_CC && ev.lsb == CC_ALL_NOTES_OFF)
            op = OP_ALL_OFF;
        else if (ev.msg == MSG_CC && ev.lsb == CC_SUSTAIN)
            op = OP_SUSTAIN;
        return op;
    endfunction

endpackage

// File: rtl/midi_msg_detect.sv
// Message edge detector, channel filter and event register for the voice allocator.
// A message only counts once CH_MESSAGE has been seen at zero after reset, so a
// message held across reset release is not taken as a new event.
module midi_msg_detect
    import midi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic [3:0] ch_message,
    input  logic [3:0] chan,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    input  logic [6:0] lsb,
    input  logic [6:0] msb,
    output logic       ev_valid,
    output logic [3:0] ev_msg,
    output logic [6:0] ev_note,
    output logic [6:0] ev_vel,
    output logic [6:0] ev_lsb,
    output logic [6:0] ev_msb,
    output logic       drop
);

    logic [3:0] prev_q, prev_d;
    logic       armed_q, armed_d;
    logic       ev_valid_q, ev_valid_d;
    logic       drop_q, drop_d;
    logic [3:0] msg_q, msg_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic [6:0] lsb_q, lsb_d;
    logic [6:0] msb_q, msb_d;
    logic       hit;
    logic       blocked;

    // Detect a rising message on our channel; load it or flag it as dropped.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        hit        = armed_q && (ch_message != 4'd0) && (prev_q == 4'd0)
                     && ((OMNI != 0) || (chan == 4'(CHANNEL)));
        blocked    = busy || ev_valid_q;
        prev_d     = ch_message;
        armed_d    = armed_q || (ch_message == 4'd0);
        ev_valid_d = hit && !blocked;
        drop_d     = hit && blocked;
        msg_d      = msg_q;
        note_d     = note_q;
        vel_d      = vel_q;
        lsb_d      = lsb_q;
        msb_d      = msb_q;
        if (ev_valid_d) begin
            msg_d  = ch_message;
            note_d = note;
            vel_d  = velocity;
            lsb_d  = lsb;
            msb_d  = msb;
        end
    end

    // Detector and event register state.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            prev_q     <= '0;
            armed_q    <= 1'b0;
            ev_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            msg_q      <= '0;
            note_q     <= '0;
            vel_q      <= '0;
            lsb_q      <= '0;
            msb_q      <= '0;
        end else begin
            prev_q     <= prev_d;
            armed_q    <= armed_d;
            ev_valid_q <= ev_valid_d;
            drop_q     <= drop_d;
            msg_q      <= msg_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            lsb_q      <= lsb_d;
            msb_q      <= msb_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign drop     = drop_q;
    assign ev_msg   = msg_q;
    assign ev_note  = note_q;
    assign ev_vel   = vel_q;
    assign ev_lsb   = lsb_q;
    assign ev_msb   = msb_q;

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: retrigger, free-voice and oldest-voice stealing.
// Define VOICE_ALLOC_SUSTAIN_EN to add sustain-pedal (CC 64) handling.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int AGE_W   = 3,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic [3:0]          CH_MESSAGE,
    input  logic [3:0]          CHAN,
    input  logic [6:0]          NOTE,
    input  logic [6:0]          VELOCITY,
    input  logic [6:0]          LSB,
    input  logic [6:0]          MSB,
    output logic [7*VOICES-1:0] VOICE_NOTE,
    output logic [7*VOICES-1:0] VOICE_VEL,
    output logic [VOICES-1:0]   VOICE_GATE,
    output logic [VOICES-1:0]   VOICE_TRIG,
    output logic                BUSY,
    output logic                DROP
);

    localparam int               IDX_W    = $clog2(VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    alloc_state_t     state_q, state_d;
    alloc_op_t        op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             match_found_q, match_found_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_found_q, free_found_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic [IDX_W-1:0] old_idx_q, old_idx_d;
    logic [AGE_W-1:0] old_age_q, old_age_d;
    logic [6:0]       note_q [VOICES];
    logic [6:0]       note_d [VOICES];
    logic [6:0]       vel_q  [VOICES];
    logic [6:0]       vel_d  [VOICES];
    logic [AGE_W-1:0] age_q  [VOICES];
    logic [AGE_W-1:0] age_d  [VOICES];
    logic [VOICES-1:0] gate_q, gate_d;
    logic [VOICES-1:0] trig_q, trig_d;
`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic              sustain_q, sustain_d;
    logic [VOICES-1:0] held_q, held_d;
`endif

    logic             ev_valid;
    logic [3:0]       ev_msg;
    logic [6:0]       ev_note, ev_vel, ev_lsb, ev_msb;
    midi_event_t      ev;
    logic             busy;
    logic [IDX_W-1:0] alloc_sel;

    assign busy = (state_q != ST_IDLE);
    assign ev   = '{msg: ev_msg, note: ev_note, vel: ev_vel, lsb: ev_lsb, msb: ev_msb};

`ifndef VOICE_ALLOC_SUSTAIN_EN
    // The controller value only matters for the sustain pedal.
    logic unused_msb;
    assign unused_msb = ^ev.msb;
`endif

    midi_msg_detect #(
        .CHANNEL (CHANNEL),
        .OMNI    (OMNI)
    ) u_detect (
        .clk        (CLK),
        .rst        (RES),
        .busy       (busy),
        .ch_message (CH_MESSAGE),
        .chan       (CHAN),
        .note       (NOTE),
        .velocity   (VELOCITY),
        .lsb        (LSB),
        .msb        (MSB),
        .ev_valid   (ev_valid),
        .ev_msg     (ev_msg),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .ev_lsb     (ev_lsb),
        .ev_msb     (ev_msb),
        .drop       (DROP)
    );

    // Allocation priority: retrigger same sounding note, else first free, else oldest.
    assign alloc_sel = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);

    // Next-state and voice update logic for IDLE -> SCAN -> COMMIT.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        idx_d         = idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        note_d        = note_q;
        vel_d         = vel_q;
        age_d         = age_q;
        gate_d        = gate_q;
        trig_d        = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
        sustain_d     = sustain_q;
        held_d        = held_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ev_valid) begin
                    op_d          = decode_op(ev);
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    case (op_d)
                        OP_ON, OP_OFF: state_d = ST_SCAN;
                        OP_ALL_OFF:    state_d = ST_COMMIT;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        OP_SUSTAIN:    state_d = ST_COMMIT;
`endif
                        default:       state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SCAN: begin
                if (gate_q[idx_q] && note_q[idx_q] == ev.note && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!gate_q[idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (idx_q == '0 || age_q[idx_q] > old_age_q) begin
                    old_idx_d = idx_q;
                    old_age_d = age_q[idx_q];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                case (op_q)
                    OP_ON: begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (IDX_W'(i) == alloc_sel) begin
                                note_d[i] = ev.note;
                                vel_d[i]  = ev.vel;
                                gate_d[i] = 1'b1;
                                trig_d[i] = 1'b1;
                                age_d[i]  = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                                held_d[i] = 1'b0;
`endif
                            end else if (age_q[i] != AGE_MAX) begin
                                age_d[i] = age_q[i] + 1'b1;
                            end
                        end
                    end
                    OP_OFF: begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (gate_q[i] && note_q[i] == ev.note) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                                if (sustain_q)
                                    held_d[i] = 1'b1;
                                else
                                    gate_d[i] = 1'b0;
`else
                                gate_d[i] = 1'b0;
`endif
                            end
                        end
                    end
                    OP_ALL_OFF: begin
                        gate_d = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
                        held_d = '0;
`endif
                    end
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    OP_SUSTAIN: begin
                        sustain_d = (ev.msb >= 7'd64);
                        if (sustain_q && !sustain_d) begin
                            gate_d = gate_q & ~held_q;
                            held_d = '0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, scan bookkeeping and voice registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NONE;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
            // NOTE: per-voice note/velocity storage drives outputs directly, so it is reset too.
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sustain_q     <= 1'b0;
            held_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            idx_q         <= idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            gate_q        <= gate_d;
            trig_q        <= trig_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            age_q         <= age_d;
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sustain_q     <= sustain_d;
            held_q        <= held_d;
`endif
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_pack
        assign VOICE_NOTE[7*g +: 7] = note_q[g];
        assign VOICE_VEL[7*g +: 7]  = vel_q[g];
    end

    assign VOICE_GATE = gate_q;
    assign VOICE_TRIG = trig_q;
    assign BUSY       = busy;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc against a voice-list reference model.
module tb_midi_voice_alloc;

    localparam int VOICES   = 4;
    localparam int AGE_MAX  = 7;
    localparam int LAT_SCAN = VOICES + 2;
    localparam int LAT_CC   = 2;

    logic CLK = 1'b0;
    logic RES, RES_OMNI;
    logic [3:0] CH_MESSAGE, CHAN;
    logic [6:0] NOTE, VELOCITY, LSB, MSB;
    logic [7*VOICES-1:0] voice_note, voice_vel, o_note, o_vel;
    logic [VOICES-1:0]   voice_gate, voice_trig, o_gate, o_trig;
    logic busy, drop, o_busy, o_drop;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    midi_voice_alloc dut (
        .CLK(CLK), .RES(RES), .CH_MESSAGE(CH_MESSAGE), .CHAN(CHAN), .NOTE(NOTE),
        .VELOCITY(VELOCITY), .LSB(LSB), .MSB(MSB), .VOICE_NOTE(voice_note),
        .VOICE_VEL(voice_vel), .VOICE_GATE(voice_gate), .VOICE_TRIG(voice_trig),
        .BUSY(busy), .DROP(drop)
    );

    midi_voice_alloc #(.OMNI(1)) dut_omni (
        .CLK(CLK), .RES(RES_OMNI), .CH_MESSAGE(CH_MESSAGE), .CHAN(CHAN), .NOTE(NOTE),
        .VELOCITY(VELOCITY), .LSB(LSB), .MSB(MSB), .VOICE_NOTE(o_note),
        .VOICE_VEL(o_vel), .VOICE_GATE(o_gate), .VOICE_TRIG(o_trig),
        .BUSY(o_busy), .DROP(o_drop)
    );

    // Reference model: a plain list of voices.
    int m_note [VOICES];
    int m_vel  [VOICES];
    int m_age  [VOICES];
    bit m_gate [VOICES];
    bit m_held [VOICES];
    bit m_sus;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < VOICES; i++) begin
            m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0; m_gate[i] = 0; m_held[i] = 0;
        end
        m_sus = 0;
    endtask

    function automatic logic [7*VOICES-1:0] exp_note();
        logic [7*VOICES-1:0] r;
        for (int i = 0; i < VOICES; i++) r[7*i +: 7] = 7'(m_note[i]);
        return r;
    endfunction

    function automatic logic [7*VOICES-1:0] exp_vel();
        logic [7*VOICES-1:0] r;
        for (int i = 0; i < VOICES; i++) r[7*i +: 7] = 7'(m_vel[i]);
        return r;
    endfunction

    function automatic logic [VOICES-1:0] exp_gate();
        logic [VOICES-1:0] r;
        for (int i = 0; i < VOICES; i++) r[i] = m_gate[i];
        return r;
    endfunction

    // Apply one message to the model; lat = 0 means the message is ignored.
    task automatic model_apply(input logic [3:0] msg, input logic [3:0] chan, input int note,
                               input int vel, input int lsb, input int msb,
                               output int lat, output logic [VOICES-1:0] trig);
        int sel;
        trig = '0;
        lat  = 0;
        if (chan != 4'd0) return;
        if (msg == 4'h9 && vel != 0) begin
            lat = LAT_SCAN;
            sel = -1;
            for (int i = 0; i < VOICES; i++)
                if (sel < 0 && m_gate[i] && m_note[i] == note) sel = i;
            for (int i = 0; i < VOICES; i++)
                if (sel < 0 && !m_gate[i]) sel = i;
            if (sel < 0) begin
                sel = 0;
                for (int i = 1; i < VOICES; i++)
                    if (m_age[i] > m_age[sel]) sel = i;
            end
            for (int i = 0; i < VOICES; i++) begin
                if (i == sel) begin
                    m_note[i] = note; m_vel[i] = vel; m_gate[i] = 1; m_age[i] = 0; m_held[i] = 0;
                end else if (m_age[i] < AGE_MAX) begin
                    m_age[i] = m_age[i] + 1;
                end
            end
            trig[sel] = 1'b1;
        end else if (msg == 4'h9 || msg == 4'h8) begin
            lat = LAT_SCAN;
            for (int i = 0; i < VOICES; i++)
                if (m_gate[i] && m_note[i] == note) begin
                    if (m_sus) m_held[i] = 1;
                    else       m_gate[i] = 0;
                end
        end else if (msg == 4'hB && lsb == 123) begin
            lat = LAT_CC;
            for (int i = 0; i < VOICES; i++) begin m_gate[i] = 0; m_held[i] = 0; end
`ifdef VOICE_ALLOC_SUSTAIN_EN
        end else if (msg == 4'hB && lsb == 64) begin
            lat = LAT_CC;
            if (m_sus && msb < 64)
                for (int i = 0; i < VOICES; i++) begin
                    if (m_held[i]) m_gate[i] = 0;
                    m_held[i] = 0;
                end
            m_sus = (msb >= 64);
`endif
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":gate"}, voice_gate, exp_gate());
        check({tag, ":note"}, voice_note, exp_note());
        check({tag, ":vel"},  voice_vel,  exp_vel());
    endtask

    // Send one message, then check latency, trigger pulse and the resulting voice state.
    task automatic do_event(input string tag, input logic [3:0] msg, input logic [3:0] chan,
                            input logic [6:0] note, input logic [6:0] vel,
                            input logic [6:0] lsb, input logic [6:0] msb);
        int lat;
        logic [VOICES-1:0] trig, gate_before;
        gate_before = exp_gate();
        @(negedge CLK);
        CH_MESSAGE = msg; CHAN = chan; NOTE = note; VELOCITY = vel; LSB = lsb; MSB = msb;
        @(negedge CLK);
        CH_MESSAGE = 4'd0;
        model_apply(msg, chan, note, vel, lsb, msb, lat, trig);
        if (lat == 0) begin
            repeat (VOICES + 3) @(negedge CLK);
            check({tag, ":idle_busy"}, busy, 1'b0);
            check({tag, ":idle_trig"}, voice_trig, '0);
        end else begin
            repeat (lat - 1) @(negedge CLK);
            check({tag, ":pre_busy"}, busy, 1'b1);
            check({tag, ":pre_gate"}, voice_gate, gate_before);
            check({tag, ":pre_trig"}, voice_trig, '0);
            @(negedge CLK);
            check({tag, ":trig"}, voice_trig, trig);
            check({tag, ":busy"}, busy, 1'b0);
            @(negedge CLK);
            check({tag, ":trig_off"}, voice_trig, '0);
        end
        check({tag, ":drop"}, drop, 1'b0);
        check_state(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        logic [3:0] m, c;
        logic [6:0] nt, v, l, mb;

        // Reset with a NOTE ON held across reset release.
        RES = 1'b1; RES_OMNI = 1'b1;
        CH_MESSAGE = 4'h9; CHAN = 4'd0; NOTE = 7'd60; VELOCITY = 7'd100; LSB = 7'd0; MSB = 7'd0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst:gate", voice_gate, '0);
        check("rst:note", voice_note, '0);
        check("rst:vel",  voice_vel,  '0);
        check("rst:trig", voice_trig, '0);
        check("rst:busy", busy, 1'b0);
        check("rst:drop", drop, 1'b0);
        RES = 1'b0;
        repeat (VOICES + 4) @(negedge CLK);
        check("held_msg:gate", voice_gate, '0);
        check("held_msg:busy", busy, 1'b0);
        CH_MESSAGE = 4'd0;
        @(negedge CLK);

        // First allocation and note off through zero velocity.
        do_event("on60", 4'h9, 4'd0, 7'd60, 7'd100, 7'd0, 7'd0);
        check("on60:voice0", voice_note[6:0], 7'd60);
        do_event("off60v0", 4'h9, 4'd0, 7'd60, 7'd0, 7'd0, 7'd0);
        check("off60v0:note_hold", voice_note[6:0], 7'd60);

        // Fill all voices, then steal the oldest, then retrigger.
        do_event("on60b", 4'h9, 4'd0, 7'd60, 7'd100, 7'd0, 7'd0);
        do_event("on62",  4'h9, 4'd0, 7'd62, 7'd90,  7'd0, 7'd0);
        do_event("on64",  4'h9, 4'd0, 7'd64, 7'd80,  7'd0, 7'd0);
        do_event("on65",  4'h9, 4'd0, 7'd65, 7'd70,  7'd0, 7'd0);
        do_event("steal67", 4'h9, 4'd0, 7'd67, 7'd60, 7'd0, 7'd0);
        check("steal67:gate_all", voice_gate, 4'b1111);
        check("steal67:voice0", voice_note[6:0], 7'd67);
        do_event("retrig64", 4'h9, 4'd0, 7'd64, 7'd33, 7'd0, 7'd0);

        // Second event while busy is dropped; only the first applies.
        @(negedge CLK);
        CH_MESSAGE = 4'h8; CHAN = 4'd0; NOTE = 7'd62; VELOCITY = 7'd0;
        @(negedge CLK);
        CH_MESSAGE = 4'd0;
        @(negedge CLK);
        CH_MESSAGE = 4'h9; NOTE = 7'd70; VELOCITY = 7'd50;
        @(negedge CLK);
        CH_MESSAGE = 4'd0;
        check("drop:pulse", drop, 1'b1);
        @(negedge CLK);
        check("drop:pulse_end", drop, 1'b0);
        begin
            int lat_a;
            logic [VOICES-1:0] trig_a;
            model_apply(4'h8, 4'd0, 62, 0, 0, 0, lat_a, trig_a);
        end
        repeat (VOICES + 3) @(negedge CLK);
        check("drop:busy", busy, 1'b0);
        check_state("drop");
        check("drop:three_gates", voice_gate, 4'b1101);

        // All notes off.
        do_event("cc123", 4'hB, 4'd0, 7'd0, 7'd0, 7'd123, 7'd0);
        check("cc123:gate", voice_gate, 4'b0000);

        // Channel filtering, and the omni instance accepting the same message.
        RES_OMNI = 1'b0;
        do_event("ch3", 4'h9, 4'd3, 7'd72, 7'd90, 7'd0, 7'd0);
        check("omni:gate", o_gate, 4'b0001);
        check("omni:note", o_note[6:0], 7'd72);
        check("omni:vel",  o_vel[6:0],  7'd90);
        RES_OMNI = 1'b1;

        // Ignored message types and controllers.
        do_event("pgm", 4'hC, 4'd0, 7'd5, 7'd0, 7'd0, 7'd0);
        do_event("cc7", 4'hB, 4'd0, 7'd0, 7'd0, 7'd7, 7'd100);

        // Reset mid-scan abandons the event.
        @(negedge CLK);
        CH_MESSAGE = 4'h9; CHAN = 4'd0; NOTE = 7'd50; VELOCITY = 7'd40;
        @(negedge CLK);
        CH_MESSAGE = 4'd0;
        repeat (2) @(negedge CLK);
        check("rst_scan:busy_before", busy, 1'b1);
        RES = 1'b1;
        @(negedge CLK);
        RES = 1'b0;
        model_reset();
        check("rst_scan:busy", busy, 1'b0);
        check("rst_scan:trig", voice_trig, '0);
        check_state("rst_scan");
        repeat (VOICES + 4) @(negedge CLK);
        check("rst_scan:gate_after", voice_gate, '0);

`ifdef VOICE_ALLOC_SUSTAIN_EN
        // Sustain pedal holds released notes until it is lifted.
        do_event("sus_on",  4'hB, 4'd0, 7'd0,  7'd0,   7'd64, 7'd127);
        do_event("sus_n60", 4'h9, 4'd0, 7'd60, 7'd100, 7'd0,  7'd0);
        do_event("sus_f60", 4'h8, 4'd0, 7'd60, 7'd0,   7'd0,  7'd0);
        check("sus:held_gate", voice_gate[0], 1'b1);
        do_event("sus_off", 4'hB, 4'd0, 7'd0,  7'd0,   7'd64, 7'd0);
        check("sus:released_gate", voice_gate[0], 1'b0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 160; n++) begin
            r  = $urandom_range(0, 99);
            c  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            nt = 7'(60 + $urandom_range(0, 5));
            v  = 7'($urandom_range(1, 127));
            l  = 7'd0;
            mb = 7'd0;
            if (r < 50)      m = 4'h9;
            else if (r < 60) begin m = 4'h9; v = 7'd0; end
            else if (r < 80) m = 4'h8;
            else if (r < 85) begin m = 4'hB; l = 7'd123; end
            else if (r < 93) begin m = 4'hB; l = 7'd64; mb = 7'($urandom_range(0, 127)); end
            else             m = 4'hC;
            do_event("rnd", m, c, nt, v, l, mb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
